// File: rtl/ps2_key_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_cmd_ctrl
// Description : Turns the PS/2 receiver byte stream into snake game commands.
//               Parses make / break / E0-extended sequences, tracks held
//               keys, drops typematic repeats and same-axis direction changes,
//               and queues surviving commands in a first-word fall-through
//               FIFO popped with a valid/ready handshake.
// Ports       : clk        system clock
//               reset      asynchronous, active-low reset
//               rx_valid   one-cycle byte strobe from the PS/2 receiver
//               rx_code    {previous byte, current byte}; only [7:0] is parsed
//               cmd_valid  FIFO head valid
//               cmd_ready  consumer accepts the head this cycle
//               cmd_code   head command: 0 UP 1 DOWN 2 LEFT 3 RIGHT 4 PAUSE 5 RESTART
//               held_keys  held state, bit index = command code
//               overflow   sticky: a command was dropped on a full FIFO
//               parse_err  one-cycle pulse on sequence timeout or illegal byte
// Options     : WASD_KEYS_EN - W/S/A/D (1D/1B/1C/23) alias the arrow keys
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_cmd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_WIDTH       = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [15:0] rx_code,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_code,
    output logic [5:0]  held_keys,
    output logic        overflow,
    output logic        parse_err
);

`ifdef WASD_KEYS_EN
    localparam bit c_WASD_EN = 1'b1;
`else
    localparam bit c_WASD_EN = 1'b0;
`endif

    localparam int                  c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]       c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [TO_WIDTH-1:0] c_TO_MAX  = TO_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [2:0]          c_UP      = 3'd0;
    localparam logic [2:0]          c_DOWN    = 3'd1;
    localparam logic [2:0]          c_LEFT    = 3'd2;
    localparam logic [2:0]          c_RIGHT   = 3'd3;
    localparam logic [2:0]          c_PAUSE   = 3'd4;
    localparam logic [2:0]          c_RESTART = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t              r_state, w_nxt;
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                r_parse_err;
    logic                w_timeout, w_make, w_brk, w_err;
    logic [2:0]          w_key;
    logic                w_arrow_hit, w_wasd_hit;
    logic [2:0]          w_arrow_key, w_wasd_key;
    logic [7:0]          w_byte;
    logic                w_unused;

    // Completed key event, processed one cycle after the closing byte
    logic                r_ev_make, r_ev_brk;
    logic [2:0]          r_ev_key;

    logic [5:0]          r_held;
    logic [2:0]          r_last_dir;
    logic                r_overflow;
    logic [2:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [c_AW:0]       r_count;
    logic                w_set, w_is_dir, w_push, w_pop, w_full, w_accept;

    assign w_byte   = rx_code[7:0];
    assign w_unused = &{1'b0, rx_code[15:8]};

    always_comb begin
        w_arrow_hit = 1'b1;
        w_arrow_key = c_UP;
        case (w_byte)
            8'h75:   w_arrow_key = c_UP;
            8'h72:   w_arrow_key = c_DOWN;
            8'h6B:   w_arrow_key = c_LEFT;
            8'h74:   w_arrow_key = c_RIGHT;
            default: w_arrow_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_wasd_hit = c_WASD_EN;
        w_wasd_key = c_UP;
        case (w_byte)
            8'h1D:   w_wasd_key = c_UP;
            8'h1B:   w_wasd_key = c_DOWN;
            8'h1C:   w_wasd_key = c_LEFT;
            8'h23:   w_wasd_key = c_RIGHT;
            default: w_wasd_hit = 1'b0;
        endcase
    end

    // A byte arriving on the timeout cycle wins; the sequence is still live.
    assign w_timeout = (r_state != ST_IDLE) && !rx_valid && (r_to_cnt == c_TO_MAX);

    always_comb begin
        w_nxt  = r_state;
        w_make = 1'b0;
        w_brk  = 1'b0;
        w_key  = c_UP;
        w_err  = 1'b0;
        if (w_timeout) begin
            w_nxt = ST_IDLE;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == 8'hE0) begin
                        w_nxt = ST_EXT;
                    end else if (w_byte == 8'hF0) begin
                        w_nxt = ST_BRK;
                    end else if (w_byte == 8'h29) begin
                        w_make = 1'b1;
                        w_key  = c_PAUSE;
                    end else if (w_byte == 8'h5A) begin
                        w_make = 1'b1;
                        w_key  = c_RESTART;
                    end else if (w_wasd_hit) begin
                        w_make = 1'b1;
                        w_key  = w_wasd_key;
                    end
                end
                ST_EXT: begin
                    w_nxt = ST_IDLE;
                    if (w_byte == 8'hF0) begin
                        w_nxt = ST_EXT_BRK;
                    end else if (w_arrow_hit) begin
                        w_make = 1'b1;
                        w_key  = w_arrow_key;
                    end
                end
                ST_BRK: begin
                    w_nxt = ST_IDLE;
                    if (w_byte == 8'hE0 || w_byte == 8'hF0) begin
                        w_err = 1'b1;
                    end else if (w_byte == 8'h29) begin
                        w_brk = 1'b1;
                        w_key = c_PAUSE;
                    end else if (w_byte == 8'h5A) begin
                        w_brk = 1'b1;
                        w_key = c_RESTART;
                    end else if (w_wasd_hit) begin
                        w_brk = 1'b1;
                        w_key = w_wasd_key;
                    end
                end
                default: begin
                    w_nxt = ST_IDLE;
                    if (w_byte == 8'hE0 || w_byte == 8'hF0) begin
                        w_err = 1'b1;
                    end else if (w_arrow_hit) begin
                        w_brk = 1'b1;
                        w_key = w_arrow_key;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_to_cnt    <= '0;
            r_parse_err <= 1'b0;
            r_ev_make   <= 1'b0;
            r_ev_brk    <= 1'b0;
            r_ev_key    <= c_UP;
        end else begin
            r_state     <= w_nxt;
            r_parse_err <= w_err | w_timeout;
            r_ev_make   <= w_make;
            r_ev_brk    <= w_brk;
            r_ev_key    <= w_key;
            if (rx_valid || (r_state == ST_IDLE) || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Directions pair on key[2:1]: UP/DOWN share 0, LEFT/RIGHT share 1, so a
    // same-axis match covers both "equal" and "opposite" to the last direction.
    assign w_set    = r_ev_make && !r_held[r_ev_key];
    assign w_is_dir = (r_ev_key[2] == 1'b0);
    assign w_push   = w_set && (!w_is_dir || (r_ev_key[2:1] != r_last_dir[2:1]));
    assign w_pop    = (r_count != '0) && cmd_ready;
    assign w_full   = (r_count == c_DEPTH);
    assign w_accept = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held     <= '0;
            r_last_dir <= c_RIGHT;
            r_overflow <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= c_UP;
            end
        end else begin
            if (r_ev_brk) begin
                r_held[r_ev_key] <= 1'b0;
            end else if (w_set) begin
                r_held[r_ev_key] <= 1'b1;
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_mem[r_wr_ptr] <= r_ev_key;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (w_is_dir) begin
                    r_last_dir <= r_ev_key;
                end else if (r_ev_key == c_RESTART) begin
                    r_last_dir <= c_RIGHT;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign cmd_valid = (r_count != '0);
    assign cmd_code  = r_mem[r_rd_ptr];
    assign held_keys = r_held;
    assign overflow  = r_overflow;
    assign parse_err = r_parse_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_cmd_ctrl
// Description : Self-checking bench for ps2_key_cmd_ctrl. Directed scenarios
//               followed by random byte streams, compared against a
//               transaction-level keyboard/queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_cmd_ctrl;

    localparam int P_DEPTH = 4;
    localparam int P_TO    = 40;
    localparam int P_TOW   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_code = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_code;
    logic [5:0]  held_keys;
    logic        overflow;
    logic        parse_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_prefix[$];
    int         m_q[$];
    logic [5:0] m_held;
    bit         m_ovf;
    int         m_last;

    ps2_key_cmd_ctrl #(
        .FIFO_DEPTH    (P_DEPTH),
        .TIMEOUT_CYCLES(P_TO),
        .TO_WIDTH      (P_TOW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_code  (rx_code),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_code (cmd_code),
        .held_keys(held_keys),
        .overflow (overflow),
        .parse_err(parse_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int arrow_code(input logic [7:0] b);
        case (b)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int wasd_code(input logic [7:0] b);
`ifdef WASD_KEYS_EN
        case (b)
            8'h1D:   return 0;
            8'h1B:   return 1;
            8'h1C:   return 2;
            8'h23:   return 3;
            default: return -1;
        endcase
`else
        if (b == 8'h00) return -1;
        return -1;
`endif
    endfunction

    // Game-level effect of one completed key event.
    task automatic model_event(input bit make, input int k);
        if (!make) begin
            m_held[k] = 1'b0;
        end else if (!m_held[k]) begin
            m_held[k] = 1'b1;
            if (k < 4 && (k / 2) == (m_last / 2)) begin
                // same axis as current heading: ignored
            end else if (m_q.size() < P_DEPTH) begin
                m_q.push_back(k);
                if (k < 4) m_last = k;
                if (k == 5) m_last = 3;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Sequence recogniser working on the byte prefix seen so far.
    task automatic model_byte(input logic [7:0] b, output bit err);
        err = 1'b0;
        if (m_prefix.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) m_prefix.push_back(b);
            else if (b == 8'h29) model_event(1, 4);
            else if (b == 8'h5A) model_event(1, 5);
            else if (wasd_code(b) >= 0) model_event(1, wasd_code(b));
        end else if (m_prefix.size() == 1 && m_prefix[0] == 8'hE0) begin
            m_prefix.delete();
            if (b == 8'hF0) begin
                m_prefix.push_back(8'hE0);
                m_prefix.push_back(8'hF0);
            end else if (arrow_code(b) >= 0) model_event(1, arrow_code(b));
        end else if (m_prefix.size() == 1) begin
            m_prefix.delete();
            if (b == 8'hE0 || b == 8'hF0) err = 1'b1;
            else if (b == 8'h29) model_event(0, 4);
            else if (b == 8'h5A) model_event(0, 5);
            else if (wasd_code(b) >= 0) model_event(0, wasd_code(b));
        end else begin
            m_prefix.delete();
            if (b == 8'hE0 || b == 8'hF0) err = 1'b1;
            else if (arrow_code(b) >= 0) model_event(0, arrow_code(b));
        end
    endtask

    task automatic model_reset();
        m_prefix.delete();
        m_q.delete();
        m_held = '0;
        m_ovf  = 1'b0;
        m_last = 3;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_held"}, 32'(held_keys), 32'(m_held));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_valid"}, 32'(cmd_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check({tag, "_code"}, 32'(cmd_code), 32'(m_q[0]));
    endtask

    // One byte strobe, then checks at the latency points.
    task automatic send_byte(input logic [7:0] b);
        bit err;
        bit pre_nonempty;
        pre_nonempty = (m_q.size() != 0);
        model_byte(b, err);
        rx_code  = {8'($urandom_range(0, 255)), b};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("parse_err", 32'(parse_err), 32'(err));
        check("valid_lat1", 32'(cmd_valid), 32'(pre_nonempty));
        tick();
        check("parse_err_pulse", 32'(parse_err), 32'(0));
        check_state("byte");
        tick();
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        for (int i = 0; i < P_DEPTH + 3; i++) begin
            if (!cmd_valid) break;
            if (m_q.size() == 0) begin
                check("drain_extra", 32'(cmd_valid), 32'(0));
                break;
            end
            check("drain_code", 32'(cmd_code), 32'(m_q.pop_front()));
            tick();
        end
        cmd_ready = 1'b0;
        check("drain_done", 32'(cmd_valid), 32'(m_q.size() != 0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int popped;
        logic [7:0] pick [12];
        pick = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'h29, 8'h5A, 8'h1D, 8'h1B, 8'h1C, 8'h23};

        model_reset();
        #1;
        check("rst_valid", 32'(cmd_valid), 32'(0));
        check("rst_code", 32'(cmd_code), 32'(0));
        check("rst_held", 32'(held_keys), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_perr", 32'(parse_err), 32'(0));
        do_reset();

        // Arrow make, reversal, release, turn, repeats
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h72);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h6B);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0); send_byte(8'h74);
        end
        drain();

        // Overflow with repeated PAUSE presses
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h29); send_byte(8'hF0); send_byte(8'h29);
        end
        check("ovf_set", 32'(overflow), 32'(1));
        drain();

        // Timeout in the middle of an extended sequence
        do_reset();
        send_byte(8'hE0);
        pulses = 0;
        first_pulse = -1;
        for (int i = 1; i <= P_TO + 10; i++) begin
            tick();
            if (parse_err) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        m_prefix.delete();
        check("to_pulses", 32'(pulses), 32'(1));
        check("to_time", 32'(first_pulse >= P_TO - 2 && first_pulse <= P_TO), 32'(1));
        send_byte(8'h75);

        // Full FIFO with simultaneous pop and RESTART push
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        drain();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h29); send_byte(8'hF0); send_byte(8'h29);
        end
        popped = m_q.pop_front();
        begin
            bit err;
            model_byte(8'h5A, err);
        end
        rx_code  = 16'h005A;
        rx_valid = 1'b1;
        tick();
        rx_valid  = 1'b0;
        cmd_ready = 1'b1;
        check("fullpop_head", 32'(cmd_code), 32'(popped));
        tick();
        cmd_ready = 1'b0;
        check_state("fullpop");
        drain();
        send_byte(8'hE0); send_byte(8'h74);
        send_byte(8'hE0); send_byte(8'h72);

        // Asynchronous reset with a partial sequence and queued commands
        send_byte(8'h29);
        send_byte(8'hE0);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(cmd_valid), 32'(0));
        check("arst_held", 32'(held_keys), 32'(0));
        check("arst_code", 32'(cmd_code), 32'(0));
        check("arst_ovf", 32'(overflow), 32'(0));
        model_reset();
        tick();
        reset = 1'b1;
        tick();
        send_byte(8'h75);

        // Random byte streams
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 85) send_byte(pick[$urandom_range(0, 11)]);
            else send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0) drain();
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
